dma_desc_arbiter: RTL and testbench

DMA_DESC_ARBITER -- requirements
Module: dma_desc_arbiter

---
 rtl/dma_desc_arbiter_if.sv | 38 +++
 rtl/dma_desc_arbiter.sv | 101 ++++++++++
 tb/tb_dma_desc_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_arbiter_if.sv
// dma_desc_arbiter_if: requester, DMA engine, completion and status bundle for dma_desc_arbiter
interface dma_desc_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 64
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*ADDR_WIDTH-1:0] req_src_addr;
  logic [NREQ*ADDR_WIDTH-1:0] req_dst_addr;
  logic [NREQ*32-1:0]         req_bytes;
  logic [NREQ*2-1:0]          req_type;
  logic                       dma_desc_valid;
  logic                       dma_desc_ready;
  logic [ADDR_WIDTH-1:0]      dma_src_addr;
  logic [ADDR_WIDTH-1:0]      dma_dst_addr;
  logic [31:0]                dma_bytes;
  logic [1:0]                 dma_type;
  logic                       dma_xfer_done;
  logic                       dma_xfer_error;
  logic [NREQ-1:0]            cpl_valid;
  logic                       cpl_error;
  logic [2:0]                 grant_id;
  logic                       busy;
  logic [31:0]                xfer_count;
  logic [31:0]                err_count;
  modport master (
    input  req_valid, req_src_addr, req_dst_addr, req_bytes, req_type,
           dma_desc_ready, dma_xfer_done, dma_xfer_error,
    output req_ready, dma_desc_valid, dma_src_addr, dma_dst_addr, dma_bytes, dma_type,
           cpl_valid, cpl_error, grant_id, busy, xfer_count, err_count
  );
  modport slave (
    output req_valid, req_src_addr, req_dst_addr, req_bytes, req_type,
           dma_desc_ready, dma_xfer_done, dma_xfer_error,
    input  req_ready, dma_desc_valid, dma_src_addr, dma_dst_addr, dma_bytes, dma_type,
           cpl_valid, cpl_error, grant_id, busy, xfer_count, err_count
  );
endinterface

// File: rtl/dma_desc_arbiter.sv
// dma_desc_arbiter: round-robin arbiter feeding one DMA engine, one transfer in flight.
// Define DMA_ARB_WATCHDOG_EN to abort ISSUE/WAIT with an error after TIMEOUT_CYC cycles.
module dma_desc_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                clk,
  input logic                rst,
  dma_desc_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_t;
  state_t          state;
  logic [IW-1:0]   rr_ptr, gnt, sel, idx;
  logic            found, wd_hit;
  logic [NREQ-1:0] gnt_oh;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NREQ);
      if (bus.req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && found) ? NREQ'(1) << sel : '0;
  assign bus.busy      = state != IDLE;
  assign bus.grant_id  = 3'(gnt);
  assign gnt_oh        = NREQ'(1) << gnt;
`ifdef DMA_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt;
  assign wd_hit = (state == ISSUE || state == WAIT) && wd_cnt >= 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_cnt <= '0;
    else     wd_cnt <= (state == ISSUE || state == WAIT) ? wd_cnt + 32'd1 : '0;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      gnt                <= '0;
      bus.dma_desc_valid <= 1'b0;
      bus.dma_src_addr   <= '0;
      bus.dma_dst_addr   <= '0;
      bus.dma_bytes      <= '0;
      bus.dma_type       <= '0;
      bus.cpl_valid      <= '0;
      bus.cpl_error      <= 1'b0;
      bus.xfer_count     <= '0;
      bus.err_count      <= '0;
    end else begin
      bus.cpl_valid <= '0;
      case (state)
        IDLE: if (found) begin
          gnt              <= sel;
          bus.dma_src_addr <= bus.req_src_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          bus.dma_dst_addr <= bus.req_dst_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          bus.dma_bytes    <= bus.req_bytes[sel*32 +: 32];
          bus.dma_type     <= bus.req_type[sel*2 +: 2];
          bus.cpl_error    <= 1'b0;
          if (bus.req_bytes[sel*32 +: 32] == 32'd0) begin
            state         <= CPL;
            bus.cpl_valid <= NREQ'(1) << sel;
          end else begin
            state              <= ISSUE;
            bus.dma_desc_valid <= 1'b1;
          end
        end
        ISSUE: if (wd_hit) begin
          state              <= CPL;
          bus.dma_desc_valid <= 1'b0;
          bus.cpl_error      <= 1'b1;
          bus.cpl_valid      <= gnt_oh;
        end else if (bus.dma_desc_ready) begin
          state              <= WAIT;
          bus.dma_desc_valid <= 1'b0;
        end
        WAIT: if (bus.dma_xfer_done || bus.dma_xfer_error || wd_hit) begin
          state         <= CPL;
          bus.cpl_error <= bus.dma_xfer_error || (wd_hit && !bus.dma_xfer_done);
          bus.cpl_valid <= gnt_oh;
        end
        CPL: begin
          state         <= IDLE;
          rr_ptr        <= IW'((int'(gnt) + 1) % NREQ);
          bus.cpl_error <= 1'b0;
          if (bus.cpl_error) bus.err_count  <= bus.err_count + 32'(~&bus.err_count);
          else               bus.xfer_count <= bus.xfer_count + 32'(~&bus.xfer_count);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_desc_arbiter.sv
// tb_dma_desc_arbiter: table-driven arbitration vectors plus directed multi-cycle corner cases
module tb_dma_desc_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dma_desc_arbiter_if #(.NREQ(N), .ADDR_WIDTH(AW)) bus();
  dma_desc_arbiter #(.NREQ(N), .ADDR_WIDTH(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] zero;
    logic       done;
    logic       err;
    logic [3:0] exp_oh;
    int         exp_lat;
    logic       exp_err;
    logic       exp_dv;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] src_of(input int k);
    return 64'hA000_0000_0000_0000 | 64'(k);
  endfunction
  function automatic logic [63:0] dst_of(input int k);
    return 64'hB000_0000_0000_0100 | 64'(k);
  endfunction
  task automatic set_req(input logic [3:0] zero);
    for (int k = 0; k < N; k++) begin
      bus.req_src_addr[k*AW +: AW] = src_of(k);
      bus.req_dst_addr[k*AW +: AW] = dst_of(k);
      bus.req_bytes[k*32 +: 32]    = zero[k] ? 32'd0 : 32'(100 + k);
      bus.req_type[k*2 +: 2]       = 2'(k);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.dma_desc_ready = 1'b0;
    bus.dma_xfer_done = 1'b0;
    bus.dma_xfer_error = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    int g;
    logic dv_seen;
    g = 0;
    for (int k = 0; k < N; k++) if (v.exp_oh[k]) g = k;
    set_req(v.zero);
    bus.req_valid = v.valid;
    bus.dma_desc_ready = 1'b1;
    bus.dma_xfer_done = v.done;
    bus.dma_xfer_error = v.err;
    #1 chk("req_ready", 64'(bus.req_ready), 64'(v.exp_oh));
    @(negedge clk);
    bus.req_valid = '0;
    n = 1;
    dv_seen = 1'b0;
    while (bus.cpl_valid == '0 && n < 12) begin
      if (bus.dma_desc_valid && !dv_seen) begin
        dv_seen = 1'b1;
        chk("grant_id", 64'(bus.grant_id), 64'(g));
        chk("dma_src_addr", bus.dma_src_addr, src_of(g));
        chk("dma_dst_addr", bus.dma_dst_addr, dst_of(g));
        chk("dma_bytes", 64'(bus.dma_bytes), 64'(100 + g));
        chk("dma_type", 64'(bus.dma_type), 64'(g));
      end
      @(negedge clk);
      n++;
    end
    chk("cpl_valid", 64'(bus.cpl_valid), 64'(v.exp_oh));
    chk("cpl_latency", 64'(n), 64'(v.exp_lat));
    chk("cpl_error", 64'(bus.cpl_error), 64'(v.exp_err));
    chk("desc_issued", 64'(dv_seen), 64'(v.exp_dv));
    bus.dma_xfer_done = 1'b0;
    bus.dma_xfer_error = 1'b0;
    @(negedge clk);
    chk("busy_after_cpl", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int n;
    vecs[0]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 4'b0010, 3, 1'b0, 1'b1};
    vecs[1]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 4'b0100, 3, 1'b0, 1'b1};
    vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000, 3, 1'b0, 1'b1};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 3, 1'b0, 1'b1};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0010, 3, 1'b0, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0100, 3, 1'b0, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000, 3, 1'b0, 1'b1};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 3, 1'b0, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 3, 1'b1, 1'b1};
    vecs[9]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 3, 1'b1, 1'b1};
    vecs[10] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1, 1'b0, 1'b0};
    vecs[11] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 4'b0001, 3, 1'b0, 1'b1};
    vecs[12] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 4'b1000, 3, 1'b0, 1'b1};
    vecs[13] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0001, 3, 1'b0, 1'b1};
    bus.req_valid = '0;
    bus.dma_desc_ready = 1'b0;
    bus.dma_xfer_done = 1'b0;
    bus.dma_xfer_error = 1'b0;
    set_req(4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_desc_valid", 64'(bus.dma_desc_valid), 64'd0);
    chk("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
    chk("rst_cpl_error", 64'(bus.cpl_error), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("rst_xfer_count", 64'(bus.xfer_count), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_dma_src", bus.dma_src_addr, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    chk("table_xfer_count", 64'(bus.xfer_count), 64'd12);
    chk("table_err_count", 64'(bus.err_count), 64'd2);
    do_reset();
    for (int i = 3; i < 8; i++) run_vec(vecs[i]);
    chk("rr5_xfer_count", 64'(bus.xfer_count), 64'd5);
    do_reset();
    run_vec(vecs[8]);
    chk("both_err_count", 64'(bus.err_count), 64'd1);
    chk("both_xfer_count", 64'(bus.xfer_count), 64'd0);
    do_reset();
    set_req(4'b0000);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    bus.req_src_addr[1*AW +: AW] = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("bp_desc_valid", 64'(bus.dma_desc_valid), 64'd1);
      chk("bp_src_stable", bus.dma_src_addr, src_of(1));
      chk("bp_req_ready_zero", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.dma_desc_ready = 1'b1;
    @(negedge clk);
    bus.dma_desc_ready = 1'b0;
    bus.req_valid = '0;
    chk("wait_desc_valid", 64'(bus.dma_desc_valid), 64'd0);
    chk("wait_src_hold", bus.dma_src_addr, src_of(1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wait_no_cpl", 64'(bus.cpl_valid), 64'd0);
      chk("wait_busy", 64'(bus.busy), 64'd1);
    end
    bus.dma_xfer_done = 1'b1;
    @(negedge clk);
    bus.dma_xfer_done = 1'b0;
    chk("bp_cpl_valid", 64'(bus.cpl_valid), 64'b0010);
    chk("bp_cpl_error", 64'(bus.cpl_error), 64'd0);
    do_reset();
    set_req(4'b0000);
    bus.req_valid = 4'b0001;
    bus.dma_desc_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy_async", 64'(bus.busy), 64'd0);
    chk("midrst_desc_valid", 64'(bus.dma_desc_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.dma_xfer_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_cpl", 64'(bus.cpl_valid), 64'd0);
    end
    bus.dma_xfer_done = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_xfer_count", 64'(bus.xfer_count), 64'd0);
    chk("midrst_err_count", 64'(bus.err_count), 64'd0);
    chk("midrst_grant_id", 64'(bus.grant_id), 64'd0);
    do_reset();
    set_req(4'b0000);
    bus.req_valid = 4'b0001;
    bus.dma_desc_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
`ifdef DMA_ARB_WATCHDOG_EN
    n = 0;
    while (bus.dma_desc_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("wd_issue_cycles", 64'(n), 64'd16);
    chk("wd_cpl_valid", 64'(bus.cpl_valid), 64'b0001);
    chk("wd_cpl_error", 64'(bus.cpl_error), 64'd1);
    @(negedge clk);
    chk("wd_err_count", 64'(bus.err_count), 64'd1);
`else
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cpl_valid != '0) n++;
    end
    chk("nowd_no_cpl", 64'(n), 64'd0);
    chk("nowd_desc_valid", 64'(bus.dma_desc_valid), 64'd1);
    chk("nowd_busy", 64'(bus.busy), 64'd1);
`endif
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
